// File: rtl/periph_mux_arbiter.sv
// N-peripheral packet arbiter: round-robin upstream drain of peripheral RX FIFOs
// with bounded bursts, and address-routed downstream writes into peripheral TX FIFOs.
module periph_mux_arbiter #(
    parameter int NUM_PERIPHS = 8,
    parameter int PACKET_W    = 32,
    parameter int ADDR_W      = 3,
    parameter int MAX_BURST   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PERIPHS-1:0]          periph_rx_empty,
    output logic [NUM_PERIPHS-1:0]          periph_rx_rden,
    input  logic [NUM_PERIPHS*PACKET_W-1:0] periph_rx_dout,
    input  logic [NUM_PERIPHS-1:0]          periph_tx_full,
    output logic [NUM_PERIPHS-1:0]          periph_tx_wren,
    output logic [PACKET_W-1:0]             periph_tx_din,
    output logic [PACKET_W-1:0]             up_data,
    output logic                            up_valid,
    input  logic                            up_ready,
    input  logic [PACKET_W-1:0]             down_data,
    input  logic                            down_valid,
    output logic                            down_ready,
    output logic [7:0]                      drop_count,
    output logic                            busy,
    output logic [1:0]                      dbg_state
);

    localparam int IW = $clog2(NUM_PERIPHS);

    // Handshakes: a transfer occurs on a rising edge where valid & ready are both high;
    // a source holds valid and data stable until that edge (up_* and down_* alike).
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SEND} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [3:0]             burst_q, burst_d;
    logic [NUM_PERIPHS-1:0] rden_q, rden_d;
    logic [PACKET_W-1:0]    up_data_q, up_data_d;
    logic                   up_valid_q, up_valid_d;
    logic [NUM_PERIPHS-1:0] wren_q, wren_d;
    logic [PACKET_W-1:0]    din_q, din_d;
    logic [7:0]             drop_q, drop_d;

    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic [IW:0]            cand;
    logic [PACKET_W-1:0]    rx_sel;

    logic [ADDR_W-1:0]      addr;
    logic                   addr_ok;
    logic                   full_sel;
    logic                   pend_sel;
    logic                   dn_hs;

    // Scan offsets from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NUM_PERIPHS; off >= 1; off--) begin
            cand = {1'b0, last_q} + (IW+1)'(off);
            if (cand >= (IW+1)'(NUM_PERIPHS)) cand = cand - (IW+1)'(NUM_PERIPHS);
            if (!periph_rx_empty[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        rx_sel = '0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (grant_q == IW'(i)) rx_sel = periph_rx_dout[i*PACKET_W +: PACKET_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        burst_d    = burst_q;
        rden_d     = '0;
        up_data_d  = up_data_q;
        up_valid_d = up_valid_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d          = pick_idx;
                    burst_d          = '0;
                    rden_d[pick_idx] = 1'b1;
                    state_d          = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                up_data_d  = rx_sel;
                up_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (up_ready) begin
                    up_valid_d = 1'b0;
                    burst_d    = burst_q + 4'd1;
                    // Empty is sampled at the handshake, so a refetch never hits an empty FIFO.
                    if (({1'b0, burst_q} + 5'd1 < 5'(MAX_BURST)) && !periph_rx_empty[grant_q]) begin
                        rden_d[grant_q] = 1'b1;
                        state_d         = S_FETCH;
                    end else begin
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pending write to the same address blocks the next packet: its full flag may be stale.
    always_comb begin
        addr     = down_data[PACKET_W-1 -: ADDR_W];
        addr_ok  = int'(addr) < NUM_PERIPHS;
        full_sel = 1'b0;
        pend_sel = 1'b0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            if (int'(addr) == i) begin
                full_sel = periph_tx_full[i];
                pend_sel = wren_q[i];
            end
        end
        down_ready = addr_ok ? ~(full_sel | pend_sel) : 1'b1;
        dn_hs      = down_valid & down_ready;
        wren_d     = '0;
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            wren_d[i] = dn_hs && (int'(addr) == i);
        end
        din_d  = (dn_hs && addr_ok) ? down_data : din_q;
        drop_d = drop_q;
        if (dn_hs && !addr_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_q     <= IW'(NUM_PERIPHS - 1);
            burst_q    <= '0;
            rden_q     <= '0;
            up_data_q  <= '0;
            up_valid_q <= 1'b0;
            wren_q     <= '0;
            din_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            rden_q     <= rden_d;
            up_data_q  <= up_data_d;
            up_valid_q <= up_valid_d;
            wren_q     <= wren_d;
            din_q      <= din_d;
            drop_q     <= drop_d;
        end
    end

    assign periph_rx_rden = rden_q;
    assign up_data        = up_data_q;
    assign up_valid       = up_valid_q;
    assign periph_tx_wren = wren_q;
    assign periph_tx_din  = din_q;
    assign drop_count     = drop_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

endmodule
